// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 access encodings, access
// sizes, load/store FSM states and small alignment helpers.
// Imported by lsu_align and mem_stage.
package mem_stage_pkg;

  // funct3 encodings for loads; stores use the low two bits only.
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_BAD = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Byte-lane mask for an access of the given size at offset 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (size_e'(sz))
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (size_e'(sz))
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus interface between the MEM stage (master) and data RAM /
// peripherals (slave). req is held with addr/we/be/wdata stable until ack.
// Ports: req, addr, we, be, wdata (master->slave); ack, rdata (slave->master).
interface mem_stage_if #(
  parameter int XLEN = 64
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            we;
  logic [7:0]      be;
  logic [XLEN-1:0] wdata;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, we, be, wdata, input ack, rdata);
  modport slave  (input req, addr, we, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Load/store alignment: byte enables, shifted store data, fault detection,
// load-result extraction and sign/zero extension. Purely combinational.
// Ports: off/funct3/is_load/is_store/st_data/rdata in; be/wdata/fault/ld_data out.
module lsu_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      off,
  input  logic [2:0]      funct3,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic            fault,
  output logic [XLEN-1:0] ld_data
);
  logic [1:0]      sz;
  logic [5:0]      bit_off;
  logic [XLEN-1:0] rsh;
  logic            illegal;

  assign sz      = funct3[1:0];
  assign bit_off = {off, 3'b000};
  // Truncation to 8 lanes is safe: only aligned accesses reach the bus.
  assign be      = size_mask(sz) << off;
  assign wdata   = st_data << bit_off;
  assign rsh     = rdata >> bit_off;

  // Loads have no funct3=111; stores have no unsigned variants.
  assign illegal = (is_load && funct3 == F3_BAD) || (is_store && funct3[2]);
  assign fault   = (is_load || is_store) && (misaligned(sz, off) || illegal);

  always_comb begin
    ld_data = rsh;
    case (funct3_e'(funct3))
      F3_LB:   ld_data = {{(XLEN-8){rsh[7]}},   rsh[7:0]};
      F3_LH:   ld_data = {{(XLEN-16){rsh[15]}}, rsh[15:0]};
      F3_LW:   ld_data = {{(XLEN-32){rsh[31]}}, rsh[31:0]};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}},     rsh[7:0]};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}},    rsh[15:0]};
      F3_LWU:  ld_data = {{(XLEN-32){1'b0}},    rsh[31:0]};
      default: ld_data = rsh;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: EXE/MEM and MEM/WB pipeline registers plus the load/store FSM.
// Latency: non-mem ops 1 cycle in M; mem ops IDLE+BUSY(n)+DONE, so >=3 cycles.
// Backpressure: memStall holds IF/ID/EXE and EXE/MEM until the bus acks or times out.
// Ports: clk/rst; E-stage inputs erd..efunc3; M fields mrd/mr/mwreg/mm2reg;
//        memStall, memFault; MEM/WB wrd/wr/wd/wm2reg/wwreg; bus (master modport).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          XLEN    = 64,
  parameter int unsigned BUS_TMO = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      erd,
  input  logic [XLEN-1:0] er,
  input  logic [XLEN-1:0] eqb,
  input  logic            ewmem,
  input  logic            em2reg,
  input  logic            ewreg,
  input  logic [2:0]      efunc3,
  output logic [4:0]      mrd,
  output logic [XLEN-1:0] mr,
  output logic            mwreg,
  output logic            mm2reg,
  output logic            memStall,
  output logic            memFault,
  output logic [4:0]      wrd,
  output logic [XLEN-1:0] wr,
  output logic [XLEN-1:0] wd,
  output logic            wm2reg,
  output logic            wwreg,
  mem_stage_if.master     bus
);
  // EXE/MEM register
  logic [4:0]      mrd_q, mrd_d;
  logic [XLEN-1:0] mr_q, mr_d, mqb_q, mqb_d;
  logic            mwmem_q, mwmem_d, mm2reg_q, mm2reg_d, mwreg_q, mwreg_d;
  logic [2:0]      mfunc3_q, mfunc3_d;
  // MEM/WB register
  logic [4:0]      wrd_q, wrd_d;
  logic [XLEN-1:0] wr_q, wr_d, wd_q, wd_d;
  logic            wm2reg_q, wm2reg_d, wwreg_q, wwreg_d;
  // Load/store control
  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
  logic [XLEN-1:0] loadbuf_q, loadbuf_d;

  logic            mem_op, align_fault, stall, busy, tmo_hit;
  logic [7:0]      be;
  logic [XLEN-1:0] wdata, ld_data;

  assign mem_op = mwmem_q | mm2reg_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .off     (mr_q[2:0]),
    .funct3  (mfunc3_q),
    .is_load (mm2reg_q),
    .is_store(mwmem_q),
    .st_data (mqb_q),
    .rdata   (bus.rdata),
    .be      (be),
    .wdata   (wdata),
    .fault   (align_fault),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    tmo_d     = 1'b0;
    loadbuf_d = loadbuf_q;
    stall     = 1'b0;
    busy      = 1'b0;
    tmo_hit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A faulting op never reaches the bus and never stalls.
        if (mem_op && !align_fault) begin
          stall   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        busy  = 1'b1;
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (bus.ack) begin
          loadbuf_d = mm2reg_q ? ld_data : '0;
          state_d   = S_DONE;
        end else if (cnt_q == 8'(BUS_TMO)) begin
          tmo_hit   = 1'b1;
          tmo_d     = 1'b1;
          loadbuf_d = '0;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mrd_d    = stall ? mrd_q    : erd;
    mr_d     = stall ? mr_q     : er;
    mqb_d    = stall ? mqb_q    : eqb;
    mwmem_d  = stall ? mwmem_q  : ewmem;
    mm2reg_d = stall ? mm2reg_q : em2reg;
    mwreg_d  = stall ? mwreg_q  : ewreg;
    mfunc3_d = stall ? mfunc3_q : efunc3;
    // While stalled WB receives an all-zero bubble so the op retires once.
    wrd_d    = '0;
    wr_d     = '0;
    wd_d     = '0;
    wm2reg_d = 1'b0;
    wwreg_d  = 1'b0;
    if (!stall) begin
      wrd_d    = mrd_q;
      wr_d     = mr_q;
      wd_d     = (state_q == S_DONE) ? loadbuf_q : '0;
      wm2reg_d = mm2reg_q;
      wwreg_d  = mwreg_q & ~align_fault & ~tmo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mrd_q <= '0; mr_q <= '0; mqb_q <= '0; mwmem_q <= 1'b0;
      mm2reg_q <= 1'b0; mwreg_q <= 1'b0; mfunc3_q <= '0;
      wrd_q <= '0; wr_q <= '0; wd_q <= '0; wm2reg_q <= 1'b0; wwreg_q <= 1'b0;
      state_q <= S_IDLE; cnt_q <= '0; tmo_q <= 1'b0; loadbuf_q <= '0;
    end else begin
      mrd_q <= mrd_d; mr_q <= mr_d; mqb_q <= mqb_d; mwmem_q <= mwmem_d;
      mm2reg_q <= mm2reg_d; mwreg_q <= mwreg_d; mfunc3_q <= mfunc3_d;
      wrd_q <= wrd_d; wr_q <= wr_d; wd_q <= wd_d; wm2reg_q <= wm2reg_d; wwreg_q <= wwreg_d;
      state_q <= state_d; cnt_q <= cnt_d; tmo_q <= tmo_d; loadbuf_q <= loadbuf_d;
    end
  end

  assign mrd       = mrd_q;
  assign mr        = mr_q;
  assign mwreg     = mwreg_q;
  assign mm2reg    = mm2reg_q;
  assign memStall  = stall;
  assign memFault  = align_fault | tmo_hit;
  assign wrd       = wrd_q;
  assign wr        = wr_q;
  assign wd        = wd_q;
  assign wm2reg    = wm2reg_q;
  assign wwreg     = wwreg_q;

  assign bus.req   = busy;
  assign bus.addr  = busy ? mr_q : '0;
  assign bus.we    = busy & mwmem_q;
  assign bus.be    = busy ? be : 8'h00;
  assign bus.wdata = busy ? wdata : '0;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected bus transfers,
// faults and writebacks into queues; a negedge monitor pops and compares.
// A bus responder acks after a programmable delay (or never).
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  erd;
  logic [63:0] er, eqb;
  logic        ewmem, em2reg, ewreg;
  logic [2:0]  efunc3;
  logic [4:0]  mrd, wrd;
  logic [63:0] mr, wr, wd;
  logic        mwreg, mm2reg, memStall, memFault, wm2reg, wwreg;

  always #5 clk = ~clk;

  mem_stage_if #(.XLEN(64)) bus ();

  mem_stage #(.XLEN(64), .BUS_TMO(255)) dut (
    .clk(clk), .rst(rst), .erd(erd), .er(er), .eqb(eqb), .ewmem(ewmem),
    .em2reg(em2reg), .ewreg(ewreg), .efunc3(efunc3),
    .mrd(mrd), .mr(mr), .mwreg(mwreg), .mm2reg(mm2reg),
    .memStall(memStall), .memFault(memFault),
    .wrd(wrd), .wr(wr), .wd(wd), .wm2reg(wm2reg), .wwreg(wwreg),
    .bus(bus)
  );

  typedef struct { logic [63:0] addr; logic we; logic [7:0] be; logic [63:0] wdata; } bus_exp_t;
  typedef struct { logic [4:0] rd; logic [63:0] r; logic [63:0] d; logic m2reg; logic wreg; } wb_exp_t;

  bus_exp_t   bus_q[$];
  wb_exp_t    wb_q[$];
  logic [4:0] flt_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT output with nothing expected", name);
  endtask

  // Bus responder: ack_delay = BUSY cycles before ack (-1 = never).
  int          ack_delay = -1;
  logic [63:0] rdata_val = '0;
  logic        ack_force = 1'b0;
  int          rsp_cnt   = 0;
  always @(negedge clk) begin
    if (bus.req) begin
      bus.ack = ((ack_delay >= 0) && (rsp_cnt == ack_delay)) || ack_force;
      rsp_cnt++;
    end else begin
      rsp_cnt = 0;
      bus.ack = ack_force;
    end
    bus.rdata = rdata_val;
  end

  // Monitor: compares each bus transfer, fault pulse and writeback.
  int run = 0;
  always @(negedge clk) begin
    bus_exp_t b;
    wb_exp_t  w;
    logic [4:0] f;
    if (rst) begin
      run = 0;
    end else begin
      if (bus.req) begin
        run++;
        if (run == 1) begin
          if (bus_q.size() == 0) fail_event("bus_unexpected");
          else begin
            b = bus_q.pop_front();
            check("bus_addr",  bus.addr,  b.addr);
            check("bus_we",    64'(bus.we), 64'(b.we));
            check("bus_be",    64'(bus.be), 64'(b.be));
            check("bus_wdata", bus.wdata, b.wdata);
          end
        end
      end else begin
        run = 0;
      end
      if (memFault) begin
        if (flt_q.size() == 0) fail_event("fault_unexpected");
        else begin
          f = flt_q.pop_front();
          check("fault_rd", 64'(mrd), 64'(f));
          if (bus.req) check("tmo_busy_cycles", 64'(run), 64'd256);
        end
      end
      if (wrd != 5'd0) begin
        if (wb_q.size() == 0) fail_event("wb_unexpected");
        else begin
          w = wb_q.pop_front();
          check("wb_rd",    64'(wrd),    64'(w.rd));
          check("wb_r",     wr,          w.r);
          check("wb_d",     wd,          w.d);
          check("wb_m2reg", 64'(wm2reg), 64'(w.m2reg));
          check("wb_wreg",  64'(wwreg),  64'(w.wreg));
        end
      end
    end
  end

  task automatic push_bus(input logic [63:0] a, input logic we, input logic [7:0] be, input logic [63:0] wdat);
    bus_exp_t b;
    b.addr = a; b.we = we; b.be = be; b.wdata = wdat;
    bus_q.push_back(b);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [63:0] r, input logic [63:0] d,
                         input logic m2reg, input logic wreg);
    wb_exp_t w;
    w.rd = rd; w.r = r; w.d = d; w.m2reg = m2reg; w.wreg = wreg;
    wb_q.push_back(w);
  endtask

  task automatic clear_e();
    erd = '0; er = '0; eqb = '0; ewmem = 1'b0; em2reg = 1'b0; ewreg = 1'b0; efunc3 = '0;
  endtask

  // Called at a negedge with memStall low; returns at the negedge where the
  // op is about to leave M, with the number of stalled cycles it caused.
  task automatic do_op(input logic [4:0] rd, input logic [63:0] r, input logic [63:0] qb,
                       input logic wmem, input logic m2reg, input logic wreg,
                       input logic [2:0] f3, output int stalls);
    erd = rd; er = r; eqb = qb; ewmem = wmem; em2reg = m2reg; ewreg = wreg; efunc3 = f3;
    @(negedge clk);
    clear_e();
    stalls = 0;
    while (memStall && stalls < 400) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stall_budget: memStall still high after %0d cycles, expected release", stalls);
    end
  endtask

  int st;

  initial begin
    clear_e();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req",  64'(bus.req),  64'd0);
    check("rst_memStall", 64'(memStall), 64'd0);
    check("rst_memFault", 64'(memFault), 64'd0);
    check("rst_mrd",      64'(mrd),      64'd0);
    check("rst_wrd",      64'(wrd),      64'd0);
    check("rst_wwreg",    64'(wwreg),    64'd0);
    rst = 1'b0;

    // sd @0x100, ack on first BUSY cycle
    ack_delay = 0;
    push_bus(64'h100, 1'b1, 8'hFF, 64'h1122334455667788);
    push_wb(5'd1, 64'h100, 64'h0, 1'b0, 1'b0);
    do_op(5'd1, 64'h100, 64'h1122334455667788, 1'b1, 1'b0, 1'b0, 3'b011, st);
    check("sd_stall", 64'(st), 64'd2);

    // lb / lbu @0x103 of 0x80
    rdata_val = 64'h0000_0000_8000_0000;
    push_bus(64'h103, 1'b0, 8'h08, 64'h0);
    push_wb(5'd2, 64'h103, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b1);
    do_op(5'd2, 64'h103, 64'h0, 1'b0, 1'b1, 1'b1, 3'b000, st);
    check("lb_stall", 64'(st), 64'd2);
    push_bus(64'h103, 1'b0, 8'h08, 64'h0);
    push_wb(5'd3, 64'h103, 64'h80, 1'b1, 1'b1);
    do_op(5'd3, 64'h103, 64'h0, 1'b0, 1'b1, 1'b1, 3'b100, st);

    // sh @0x106
    push_bus(64'h106, 1'b1, 8'hC0, 64'hABCD_0000_0000_0000);
    push_wb(5'd4, 64'h106, 64'h0, 1'b0, 1'b0);
    do_op(5'd4, 64'h106, 64'hABCD, 1'b1, 1'b0, 1'b0, 3'b001, st);

    // misaligned lw @0x102: fault, no bus, no stall
    flt_q.push_back(5'd5);
    push_wb(5'd5, 64'h102, 64'h0, 1'b1, 1'b0);
    do_op(5'd5, 64'h102, 64'h0, 1'b0, 1'b1, 1'b1, 3'b010, st);
    check("lw_misal_stall", 64'(st), 64'd0);

    // plain ALU op passes in one cycle
    push_wb(5'd6, 64'h1234, 64'h0, 1'b0, 1'b1);
    do_op(5'd6, 64'h1234, 64'h0, 1'b0, 1'b0, 1'b1, 3'b000, st);
    check("alu_stall", 64'(st), 64'd0);

    // ld @0x108 with ack on third BUSY cycle
    ack_delay = 2;
    rdata_val = 64'hDEAD_BEEF_CAFE_F00D;
    push_bus(64'h108, 1'b0, 8'hFF, 64'h0);
    push_wb(5'd7, 64'h108, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b1);
    do_op(5'd7, 64'h108, 64'h0, 1'b0, 1'b1, 1'b1, 3'b011, st);
    check("ld_stall", 64'(st), 64'd4);
    ack_delay = 0;

    // lh @0x10A
    rdata_val = 64'h0000_0000_8001_0000;
    push_bus(64'h10A, 1'b0, 8'h0C, 64'h0);
    push_wb(5'd8, 64'h10A, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b1);
    do_op(5'd8, 64'h10A, 64'h0, 1'b0, 1'b1, 1'b1, 3'b001, st);

    // lwu / lw @0x104
    rdata_val = 64'hF000_0000_0000_0000;
    push_bus(64'h104, 1'b0, 8'hF0, 64'h0);
    push_wb(5'd9, 64'h104, 64'h0000_0000_F000_0000, 1'b1, 1'b1);
    do_op(5'd9, 64'h104, 64'h0, 1'b0, 1'b1, 1'b1, 3'b110, st);
    push_bus(64'h104, 1'b0, 8'hF0, 64'h0);
    push_wb(5'd10, 64'h104, 64'hFFFF_FFFF_F000_0000, 1'b1, 1'b1);
    do_op(5'd10, 64'h104, 64'h0, 1'b0, 1'b1, 1'b1, 3'b010, st);

    // illegal load funct3=111 and illegal store funct3=100
    flt_q.push_back(5'd11);
    push_wb(5'd11, 64'h100, 64'h0, 1'b1, 1'b0);
    do_op(5'd11, 64'h100, 64'h0, 1'b0, 1'b1, 1'b1, 3'b111, st);
    flt_q.push_back(5'd12);
    push_wb(5'd12, 64'h100, 64'h0, 1'b0, 1'b0);
    do_op(5'd12, 64'h100, 64'h5, 1'b1, 1'b0, 1'b0, 3'b100, st);

    // sw @0x10C
    push_bus(64'h10C, 1'b1, 8'hF0, 64'hCAFE_BABE_0000_0000);
    push_wb(5'd13, 64'h10C, 64'h0, 1'b0, 1'b0);
    do_op(5'd13, 64'h10C, 64'hCAFE_BABE, 1'b1, 1'b0, 1'b0, 3'b010, st);

    // lw @0x110, ack withheld: timeout after 255 BUSY cycles
    ack_delay = -1;
    push_bus(64'h110, 1'b0, 8'h0F, 64'h0);
    flt_q.push_back(5'd14);
    push_wb(5'd14, 64'h110, 64'h0, 1'b1, 1'b0);
    do_op(5'd14, 64'h110, 64'h0, 1'b0, 1'b1, 1'b1, 3'b010, st);
    check("tmo_stall", 64'(st), 64'd257);

    // pipeline recovers: lbu @0x111
    ack_delay = 0;
    rdata_val = 64'h0000_0000_0000_AB00;
    push_bus(64'h111, 1'b0, 8'h02, 64'h0);
    push_wb(5'd15, 64'h111, 64'hAB, 1'b1, 1'b1);
    do_op(5'd15, 64'h111, 64'h0, 1'b0, 1'b1, 1'b1, 3'b100, st);

    // reset mid-BUSY, then a late ack that must be ignored
    ack_delay = -1;
    push_bus(64'h118, 1'b0, 8'h0F, 64'h0);
    erd = 5'd20; er = 64'h118; em2reg = 1'b1; ewreg = 1'b1; efunc3 = 3'b010;
    @(negedge clk);
    clear_e();
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 64'(bus.req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstb_bus_req",  64'(bus.req),  64'd0);
    check("rstb_memStall", 64'(memStall), 64'd0);
    check("rstb_mrd",      64'(mrd),      64'd0);
    check("rstb_wwreg",    64'(wwreg),    64'd0);
    rst = 1'b0;
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_bus_req",  64'(bus.req),  64'd0);
      check("late_ack_memStall", 64'(memStall), 64'd0);
      check("late_ack_wrd",      64'(wrd),      64'd0);
    end
    ack_force = 1'b0;

    repeat (3) @(negedge clk);
    check("bus_q_left", 64'(bus_q.size()), 64'd0);
    check("wb_q_left",  64'(wb_q.size()),  64'd0);
    check("flt_q_left", 64'(flt_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
